// File: rtl/legv8_mem_stage.sv
// LEGv8 memory-access stage: doubleword data memory, branch resolution with
// wrong-path squashing, and the MEM/WB pipeline register.
module legv8_mem_stage #(
  parameter int MEM_WORDS    = 256,
  parameter int SQUASH_DEPTH = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [63:0] ALU_result,
  input  logic [63:0] RD2,
  input  logic [63:0] Br_Tar,
  input  logic        is_zero,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Branch,
  input  logic        UncondBranch,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic [4:0]  Rd,
  output logic        wb_valid,
  output logic        wb_RegWrite,
  output logic [4:0]  wb_Rd,
  output logic [63:0] wb_data,
  output logic        PCSrc,
  output logic [63:0] PC_target,
  output logic        align_err
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int SW = (SQUASH_DEPTH >= 1) ? $clog2(SQUASH_DEPTH + 1) : 1;

  logic [63:0]   mem [MEM_WORDS];
  logic [SW-1:0] squash_cnt;
  logic [AW-1:0] idx;
  logic          live;
  logic          squashed;
  logic          misalign;
  logic          conflict;
  logic          store_en;
  logic          taken;
  logic          reg_we;
  logic          addr_unused;

  // Upper address bits are deliberately dropped so accesses wrap around memory.
  assign idx         = ALU_result[AW+2:3];
  assign addr_unused = ^{ALU_result[63:AW+3]};

  always_comb begin
    live     = in_valid && (squash_cnt == '0);
    squashed = in_valid && (squash_cnt != '0);
    misalign = (MemRead || MemWrite) && (ALU_result[2:0] != 3'b000);
    conflict = MemRead && MemWrite;
    store_en = live && MemWrite && !misalign;
    taken    = live && ((Branch && is_zero) || UncondBranch);
    reg_we   = live && RegWrite && !misalign && !conflict;
  end

  // Memory has no reset so committed data survives a pipeline reset.
  always_ff @(posedge clk) begin
    if (store_en)
      mem[idx] <= RD2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid    <= 1'b0;
      wb_RegWrite <= 1'b0;
      wb_Rd       <= 5'd0;
      wb_data     <= 64'd0;
      PCSrc       <= 1'b0;
      PC_target   <= 64'd0;
      align_err   <= 1'b0;
      squash_cnt  <= '0;
    end else begin
      wb_valid    <= in_valid;
      wb_RegWrite <= reg_we;
      PCSrc       <= taken;
      if (live) begin
        wb_Rd   <= Rd;
        wb_data <= MemtoReg ? mem[idx] : ALU_result;
      end
      if (taken)
        PC_target <= Br_Tar;
      if (live && (misalign || conflict))
        align_err <= 1'b1;
      // A squashed branch never reloads the counter, only a live one does.
      if (taken)
        squash_cnt <= SW'(SQUASH_DEPTH);
      else if (squashed)
        squash_cnt <= squash_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_legv8_mem_stage.sv
// Directed self-checking bench for legv8_mem_stage: loads/stores, branch
// squashing, misalignment, address wrap and asynchronous reset.
module tb_legv8_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] ALU_result;
  logic [63:0] RD2;
  logic [63:0] Br_Tar;
  logic        is_zero;
  logic        MemRead, MemWrite, Branch, UncondBranch, RegWrite, MemtoReg;
  logic [4:0]  Rd;
  logic        wb_valid, wb_RegWrite, PCSrc, align_err;
  logic [4:0]  wb_Rd;
  logic [63:0] wb_data, PC_target;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  legv8_mem_stage #(.MEM_WORDS(256), .SQUASH_DEPTH(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ALU_result(ALU_result),
    .RD2(RD2), .Br_Tar(Br_Tar), .is_zero(is_zero), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch), .UncondBranch(UncondBranch),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Rd(Rd), .wb_valid(wb_valid),
    .wb_RegWrite(wb_RegWrite), .wb_Rd(wb_Rd), .wb_data(wb_data),
    .PCSrc(PCSrc), .PC_target(PC_target), .align_err(align_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one instruction, then sample 1 time unit after the capturing edge.
  task automatic issue(input logic v, input logic [63:0] addr, input logic [63:0] sd,
                       input logic [63:0] tar, input logic br, input logic z,
                       input logic ub, input logic mr, input logic mw,
                       input logic rw, input logic m2r, input logic [4:0] rd);
    in_valid = v; ALU_result = addr; RD2 = sd; Br_Tar = tar; Branch = br;
    is_zero = z; UncondBranch = ub; MemRead = mr; MemWrite = mw;
    RegWrite = rw; MemtoReg = m2r; Rd = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [63:0] addr, input logic [63:0] sd, input logic rw);
    issue(1'b1, addr, sd, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rw, 1'b0, 5'd0);
  endtask

  task automatic load(input logic [63:0] addr, input logic [4:0] rd);
    issue(1'b1, addr, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, rd);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, {63'd0, wb_valid}, 64'd0);
    check({tag, "_regwrite"}, {63'd0, wb_RegWrite}, 64'd0);
    check({tag, "_rd"}, {59'd0, wb_Rd}, 64'd0);
    check({tag, "_data"}, wb_data, 64'd0);
    check({tag, "_pcsrc"}, {63'd0, PCSrc}, 64'd0);
    check({tag, "_pctarget"}, PC_target, 64'd0);
    check({tag, "_alignerr"}, {63'd0, align_err}, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    issue(1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    check_cleared("reset");
    @(negedge clk);
    reset = 1'b0;

    // Store then load on the next cycle.
    store(64'h10, 64'hDEAD_BEEF_0123_4567, 1'b0);
    check("st_valid", {63'd0, wb_valid}, 64'd1);
    check("st_regwrite", {63'd0, wb_RegWrite}, 64'd0);
    load(64'h10, 5'd9);
    check("ld_data", wb_data, 64'hDEAD_BEEF_0123_4567);
    check("ld_rd", {59'd0, wb_Rd}, 64'd9);
    check("ld_regwrite", {63'd0, wb_RegWrite}, 64'd1);

    // Not-taken conditional branch: nothing squashed afterwards.
    issue(1'b1, 64'd0, 64'd0, 64'h800, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    check("nt_pcsrc", {63'd0, PCSrc}, 64'd0);
    store(64'h20, 64'hA1A1_A1A1_A1A1_A1A1, 1'b0);
    load(64'h20, 5'd3);
    check("nt_data", wb_data, 64'hA1A1_A1A1_A1A1_A1A1);
    check("nt_regwrite", {63'd0, wb_RegWrite}, 64'd1);

    // Taken CBZ, a bubble, then three squashed stores and a live load.
    issue(1'b1, 64'd0, 64'd0, 64'h400, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    check("tk_pcsrc", {63'd0, PCSrc}, 64'd1);
    check("tk_target", PC_target, 64'h400);
    issue(1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    check("tk_pulse_end", {63'd0, PCSrc}, 64'd0);
    check("bubble_valid", {63'd0, wb_valid}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      store(64'h20, 64'hB0 + 64'(i), 1'b1);
      check($sformatf("sq%0d_valid", i), {63'd0, wb_valid}, 64'd1);
      check($sformatf("sq%0d_regwrite", i), {63'd0, wb_RegWrite}, 64'd0);
    end
    load(64'h20, 5'd4);
    check("post_sq_data", wb_data, 64'hA1A1_A1A1_A1A1_A1A1);
    check("post_sq_regwrite", {63'd0, wb_RegWrite}, 64'd1);
    check("post_sq_rd", {59'd0, wb_Rd}, 64'd4);

    // Address wrap: 0x800 aliases address 0.
    store(64'h0, 64'hC0C0_0000_0000_C0C0, 1'b0);
    load(64'h800, 5'd7);
    check("wrap_data", wb_data, 64'hC0C0_0000_0000_C0C0);

    // Misaligned load sets the sticky error flag.
    check("align_pre", {63'd0, align_err}, 64'd0);
    load(64'h13, 5'd8);
    check("mis_alignerr", {63'd0, align_err}, 64'd1);
    check("mis_regwrite", {63'd0, wb_RegWrite}, 64'd0);
    load(64'h10, 5'd5);
    check("sticky_alignerr", {63'd0, align_err}, 64'd1);
    check("sticky_data", wb_data, 64'hDEAD_BEEF_0123_4567);
    check("sticky_regwrite", {63'd0, wb_RegWrite}, 64'd1);

    // Unconditional branch, one squashed store, then reset mid-squash.
    issue(1'b1, 64'd0, 64'd0, 64'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    check("ub_pcsrc", {63'd0, PCSrc}, 64'd1);
    check("ub_target", PC_target, 64'h1234);
    store(64'h10, 64'hE1E1_E1E1_E1E1_E1E1, 1'b1);
    check("ub_sq_regwrite", {63'd0, wb_RegWrite}, 64'd0);
    reset = 1'b1;
    #1;
    check_cleared("midreset");
    @(negedge clk);
    reset = 1'b0;

    store(64'h30, 64'hF1F1_0000_1111_2222, 1'b0);
    check("rst_st_valid", {63'd0, wb_valid}, 64'd1);
    load(64'h30, 5'd11);
    check("rst_ld_data", wb_data, 64'hF1F1_0000_1111_2222);
    check("rst_ld_regwrite", {63'd0, wb_RegWrite}, 64'd1);
    check("rst_ld_rd", {59'd0, wb_Rd}, 64'd11);
    load(64'h10, 5'd12);
    check("retain_10", wb_data, 64'hDEAD_BEEF_0123_4567);
    load(64'h20, 5'd13);
    check("retain_20", wb_data, 64'hA1A1_A1A1_A1A1_A1A1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/legv8_mem_stage.md
# legv8_mem_stage

Memory-access stage of the LEGv8 pipeline. It is the consumer of the execute stage's ALU result, zero flag, branch target and store data. It performs doubleword loads and stores against an internal data memory, resolves conditional and unconditional branches, and squashes wrong-path instructions after a taken branch. All results are registered into the MEM/WB boundary for the writeback stage and the fetch stage.

## Interface
- MEM_WORDS, 256: data-memory depth in 64-bit doublewords; power of two.
- SQUASH_DEPTH, 3: number of valid instructions squashed after a taken branch.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  EX outputs and control carry a live instruction this cycle.
- ALU_result  in  64  byte address for load/store; passthrough value for ALU ops.
- RD2  in  64  store data.
- Br_Tar  in  64  branch target from EX.
- is_zero  in  1  ALU zero flag.
- MemRead, MemWrite, Branch, UncondBranch, RegWrite, MemtoReg  in  1 each  decoded control.
- Rd  in  5  destination register.
- wb_valid  out  1  registered: MEM/WB holds a live instruction.
- wb_RegWrite  out  1  registered register-file write enable.
- wb_Rd  out  5  registered destination.
- wb_data  out  64  registered writeback value: load data if MemtoReg, else ALU_result.
- PCSrc  out  1  registered one-cycle pulse: redirect fetch.
- PC_target  out  64  registered branch target, valid while PCSrc = 1.
- align_err  out  1  sticky misaligned-access or read/write-conflict flag.

## Operation
- Word index is ALU_result[log2(MEM_WORDS)+2 : 3]. Upper address bits are ignored, so addresses wrap modulo MEM_WORDS*8.
- An instruction is live when in_valid = 1 and squash_cnt = 0.
- A valid instruction with squash_cnt > 0 is squashed:
  - no memory write, no PCSrc;
  - wb_valid = 1 with wb_RegWrite = 0;
  - squash_cnt decrements.
- Cycles with in_valid = 0 do not decrement squash_cnt.
- Store: a live instruction with MemWrite and ALU_result[2:0] = 0 writes RD2 to mem[index] at the clock edge.
- Load: a live instruction with MemRead reads mem[index] synchronously. The data is captured into wb_data at the same edge that registers the rest of the instruction.
- Misaligned access (MemRead or MemWrite with ALU_result[2:0] ≠ 0):
  - the access is suppressed and wb_RegWrite forced to 0;
  - align_err is set.
- MemRead and MemWrite both asserted: treated as a store only, wb_RegWrite forced to 0, align_err set.
- align_err clears only on reset.
- Branch taken when a live instruction has (Branch & is_zero) | UncondBranch:
  - PCSrc = 1 and PC_target = Br_Tar on the next edge;
  - squash_cnt loads SQUASH_DEPTH.
- A branch arriving while squash_cnt > 0 is itself squashed and ignored.
- Memory contents are not affected by reset.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on wb_*, PCSrc and PC_target after edge N.
- in_valid = 0 at edge N gives wb_valid = 0, wb_RegWrite = 0 and PCSrc = 0 after edge N. wb_data and wb_Rd hold their previous values.
- PCSrc is high for exactly one cycle per taken branch.
- Store-then-load to the same address on consecutive cycles: the load returns the new data, because the write completes at edge N and the read is at edge N+1.
- Reset (asynchronous, immediate):
  - wb_valid, wb_RegWrite, wb_Rd, wb_data, PCSrc, PC_target, align_err and squash_cnt all go to 0.
  - Asserting reset mid-squash abandons the squash; the first valid instruction after reset release is live.
  - Reset does not cancel a write already committed at a prior edge.

## Test plan
- Store RD2 = 64'hDEAD_BEEF_0123_4567 to ALU_result = 0x10, then load 0x10 with MemtoReg = 1, RegWrite = 1, Rd = 9 on the next cycle -> wb_data = 64'hDEAD_BEEF_0123_4567, wb_Rd = 9, wb_RegWrite = 1 one cycle after the load.
- CBZ-style Branch = 1, is_zero = 1, Br_Tar = 0x400 -> PCSrc pulses for one cycle with PC_target = 0x400. The next 3 valid stores are dropped (reload shows the old data) and give wb_RegWrite = 0. The 4th valid instruction executes normally.
- Branch = 1, is_zero = 0 -> PCSrc stays 0 and the following instruction is not squashed.
- Load at ALU_result = 0x13 -> align_err = 1, wb_RegWrite = 0; align_err stays 1 through later aligned traffic until reset.
- Store to address 0 then load address MEM_WORDS*8 -> the load returns the stored value (wrap).
- Taken branch, then reset asserted after one squashed instruction -> all outputs 0 immediately. After release, a store/load pair executes normally and the memory retains data written before reset.
